// File: rtl/stochastic_to_binary_if.sv
// ============================================================================
// Module   : stochastic_to_binary_if
// Brief    : Stream-in / result-out bundle for the stochastic-to-binary counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stochastic_to_binary_if #(
   parameter int CW = 4
);
   logic          start;
   logic          bit_valid;
   logic          bit_in;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;

   modport master (
      output start, bit_valid, bit_in, out_ready,
      input  busy, out_valid, count
   );

   modport slave (
      input  start, bit_valid, bit_in, out_ready,
      output busy, out_valid, count
   );
endinterface

`default_nettype wire

// File: rtl/stochastic_to_binary.sv
// ============================================================================
// Module   : stochastic_to_binary
// Brief    : Counts the ones in an N-bit serial unipolar stochastic window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stochastic_to_binary #(
   parameter int N  = 16384,
   parameter int CW = $clog2(N + 1),
   parameter int LW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   stochastic_to_binary_if.slave sb
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [LW-1:0] c_last = LW'(N - 1);

   state_t        r_state;
   logic [CW-1:0] r_ones;
   logic [LW-1:0] r_len;
   logic [CW-1:0] r_count;
   logic          r_busy;
   logic          r_out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ones      <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sb.start) begin
                  r_ones  <= '0;
                  r_len   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (sb.bit_valid) begin
                  // The Nth bit goes straight into the result; the CW-bit sum cannot wrap.
                  if (r_len == c_last) begin
                     r_count     <= r_ones + CW'(sb.bit_in);
                     r_busy      <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end else begin
                     r_len  <= r_len + LW'(1);
                     r_ones <= r_ones + CW'(sb.bit_in);
                  end
               end
            end
            S_HOLD: begin
               if (sb.out_ready) begin
                  r_out_valid <= 1'b0;
                  // A start accepted with the handshake opens the next window without a gap.
                  if (sb.start) begin
                     r_ones  <= '0;
                     r_len   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= S_ACCUM;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign sb.busy      = r_busy;
   assign sb.out_valid = r_out_valid;
   assign sb.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_stochastic_to_binary.sv
// Bench for stochastic_to_binary: an N=8 instance for the windowing/handshake
// cases and a default-size instance driven by LFSR streams.
`default_nettype none

module tb_stochastic_to_binary;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   bit qv[$];
   bit qb[$];

   always #5 clk = ~clk;

   stochastic_to_binary_if #(.CW(4))  ifa ();
   stochastic_to_binary_if #(.CW(15)) ifb ();

   stochastic_to_binary #(.N(8)) dut_a (.clk(clk), .rst(rst), .sb(ifa));
   stochastic_to_binary          dut_b (.clk(clk), .rst(rst), .sb(ifb));

   // Reference: ones among the first nvalid accepted bits of the queued stream.
   function automatic int model_ones(input int nvalid);
      int seen = 0;
      int ones = 0;
      for (int i = 0; i < qv.size(); i++) begin
         if (qv[i] && seen < nvalid) begin
            seen++;
            ones += int'(qb[i]);
         end
      end
      return ones;
   endfunction

   // mode 0 random, 1 all ones, 2 all zeros; idle gaps drive bit_in=1.
   task automatic build_a(input int mode, input int gap_max);
      qv.delete();
      qb.delete();
      for (int i = 0; i < 8; i++) begin
         int gaps = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
         for (int g = 0; g < gaps; g++) begin
            qv.push_back(1'b0);
            qb.push_back(1'b1);
         end
         qv.push_back(1'b1);
         qb.push_back(mode == 1 ? 1'b1 : (mode == 2 ? 1'b0 : 1'($urandom)));
      end
   endtask

   // Called on a negedge; returns on the negedge after the last queued bit.
   task automatic run_a(input bit do_start, output int busy_cnt, output bit early_ov);
      busy_cnt = 0;
      early_ov = 1'b0;
      if (do_start) begin
         ifa.start = 1'b1;
         @(negedge clk);
         ifa.start = 1'b0;
      end
      for (int i = 0; i < qv.size(); i++) begin
         ifa.bit_valid = qv[i];
         ifa.bit_in    = qb[i];
         if (ifa.busy === 1'b1) busy_cnt++;
         if (ifa.out_valid !== 1'b0) early_ov = 1'b1;
         @(negedge clk);
      end
      ifa.bit_valid = 1'b0;
      ifa.bit_in    = 1'b0;
   endtask

   task automatic consume_a(input bit with_start);
      ifa.out_ready = 1'b1;
      ifa.start     = with_start;
      @(negedge clk);
      ifa.out_ready = 1'b0;
      ifa.start     = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy_a got %b want 0", ifa.busy); end
      checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_a got %b want 0", ifa.out_valid); end
      checks++; if (ifa.count !== 4'd0) begin failures++; $display("FAIL reset_count_a got %0d want 0", ifa.count); end
      checks++; if (ifb.out_valid !== 1'b0 || ifb.busy !== 1'b0 || ifb.count !== 15'd0) begin
         failures++; $display("FAIL reset_b got busy=%b valid=%b count=%0d want 0/0/0", ifb.busy, ifb.out_valid, ifb.count);
      end
   endtask

   // Window checks shared shape: busy per bit, no early valid, valid one cycle after Nth bit.
   task automatic test_pattern();
      int  bc;
      bit  eo;
      bit  pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      qv.delete();
      qb.delete();
      for (int i = 0; i < 8; i++) begin
         qv.push_back(1'b1);
         qb.push_back(pat[i]);
      end
      run_a(1'b1, bc, eo);
      checks++; if (bc != 8) begin failures++; $display("FAIL pattern_busy_cycles got %0d want 8", bc); end
      checks++; if (eo) begin failures++; $display("FAIL pattern_early_valid got 1 want 0"); end
      checks++; if (ifa.out_valid !== 1'b1 || ifa.busy !== 1'b0) begin
         failures++; $display("FAIL pattern_latency got valid=%b busy=%b want 1/0", ifa.out_valid, ifa.busy);
      end
      checks++; if (ifa.count !== 4'(model_ones(8))) begin failures++; $display("FAIL pattern_count got %0d want %0d", ifa.count, model_ones(8)); end
      consume_a(1'b0);
      checks++; if (ifa.out_valid !== 1'b0 || ifa.count !== 4'd4) begin
         failures++; $display("FAIL pattern_after_hs got valid=%b count=%0d want 0/4", ifa.out_valid, ifa.count);
      end
   endtask

   task automatic test_extremes();
      int bc;
      bit eo;
      build_a(1, 0);
      run_a(1'b1, bc, eo);
      checks++; if (ifa.out_valid !== 1'b1 || ifa.count !== 4'd8) begin
         failures++; $display("FAIL all_ones got valid=%b count=%0d want 1/8", ifa.out_valid, ifa.count);
      end
      consume_a(1'b0);
      build_a(2, 0);
      run_a(1'b1, bc, eo);
      checks++; if (ifa.out_valid !== 1'b1 || ifa.count !== 4'd0) begin
         failures++; $display("FAIL all_zeros got valid=%b count=%0d want 1/0", ifa.out_valid, ifa.count);
      end
      consume_a(1'b0);
   endtask

   task automatic test_gaps();
      int bc;
      bit eo;
      for (int r = 0; r < 6; r++) begin
         build_a(0, 3);
         run_a(1'b1, bc, eo);
         checks++; if (bc != qv.size() || eo || ifa.out_valid !== 1'b1) begin
            failures++; $display("FAIL gaps_timing[%0d] got busy_cycles=%0d early=%b valid=%b want %0d/0/1", r, bc, eo, ifa.out_valid, qv.size());
         end
         checks++; if (ifa.count !== 4'(model_ones(8))) begin
            failures++; $display("FAIL gaps_count[%0d] got %0d want %0d", r, ifa.count, model_ones(8));
         end
         consume_a(1'b0);
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      bit eo;
      int exp;
      build_a(1, 0);
      qb[0] = 1'b0;
      exp = model_ones(8);
      run_a(1'b1, bc, eo);
      for (int k = 0; k < 5; k++) begin
         ifa.start     = k[0];
         ifa.bit_valid = 1'b1;
         ifa.bit_in    = 1'b1;
         @(negedge clk);
         checks++; if (ifa.out_valid !== 1'b1 || ifa.busy !== 1'b0 || ifa.count !== 4'(exp)) begin
            failures++; $display("FAIL hold_stable[%0d] got valid=%b busy=%b count=%0d want 1/0/%0d", k, ifa.out_valid, ifa.busy, ifa.count, exp);
         end
      end
      ifa.bit_valid = 1'b0;
      ifa.bit_in    = 1'b0;
      consume_a(1'b1);
      checks++; if (ifa.busy !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.count !== 4'(exp)) begin
         failures++; $display("FAIL b2b_restart got busy=%b valid=%b count=%0d want 1/0/%0d", ifa.busy, ifa.out_valid, ifa.count, exp);
      end
      build_a(0, 2);
      run_a(1'b0, bc, eo);
      checks++; if (ifa.out_valid !== 1'b1 || ifa.count !== 4'(model_ones(8)) || bc != qv.size()) begin
         failures++; $display("FAIL b2b_window got valid=%b count=%0d busy_cycles=%0d want 1/%0d/%0d", ifa.out_valid, ifa.count, bc, model_ones(8), qv.size());
      end
      consume_a(1'b0);
   endtask

   task automatic test_async_reset();
      int bc;
      bit eo;
      build_a(1, 0);
      run_a(1'b1, bc, eo);
      consume_a(1'b0);
      qv.delete();
      qb.delete();
      for (int i = 0; i < 3; i++) begin
         qv.push_back(1'b1);
         qb.push_back(1'b1);
      end
      run_a(1'b1, bc, eo);
      #2 rst = 1'b1;
      #1;
      checks++; if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.count !== 4'd0) begin
         failures++; $display("FAIL async_reset got busy=%b valid=%b count=%0d want 0/0/0", ifa.busy, ifa.out_valid, ifa.count);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      build_a(1, 0);
      run_a(1'b1, bc, eo);
      checks++; if (ifa.out_valid !== 1'b1 || ifa.count !== 4'd8 || bc != 8) begin
         failures++; $display("FAIL post_reset_window got valid=%b count=%0d busy_cycles=%0d want 1/8/8", ifa.out_valid, ifa.count, bc);
      end
      consume_a(1'b0);
   endtask

   task automatic test_long();
      logic [15:0] la = 16'hACE1;
      logic [15:0] lb = 16'h1D2B;
      int exp = 0;
      int bc  = 0;
      bit eo  = 1'b0;
      bit b;
      ifb.start = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0;
      for (int i = 0; i < 16384; i++) begin
         b  = la[0] & (lb[0] & lb[1]);
         exp += int'(b);
         ifb.bit_valid = 1'b1;
         ifb.bit_in    = b;
         if (ifb.busy === 1'b1) bc++;
         if (ifb.out_valid !== 1'b0) eo = 1'b1;
         la = {la[14:0], la[15] ^ la[13] ^ la[12] ^ la[10]};
         lb = {lb[14:0], lb[15] ^ lb[13] ^ lb[12] ^ lb[10]};
         @(negedge clk);
      end
      ifb.bit_valid = 1'b0;
      ifb.bit_in    = 1'b0;
      checks++; if (bc != 16384 || eo) begin failures++; $display("FAIL long_busy got busy_cycles=%0d early=%b want 16384/0", bc, eo); end
      checks++; if (ifb.out_valid !== 1'b1 || ifb.busy !== 1'b0) begin
         failures++; $display("FAIL long_latency got valid=%b busy=%b want 1/0", ifb.out_valid, ifb.busy);
      end
      checks++; if (ifb.count !== 15'(exp)) begin failures++; $display("FAIL long_count got %0d want %0d", ifb.count, exp); end
      ifb.out_ready = 1'b1;
      @(negedge clk);
      ifb.out_ready = 1'b0;
      checks++; if (ifb.out_valid !== 1'b0 || ifb.count !== 15'(exp)) begin
         failures++; $display("FAIL long_after_hs got valid=%b count=%0d want 0/%0d", ifb.out_valid, ifb.count, exp);
      end
   endtask

   initial begin
      ifa.start = 1'b0; ifa.bit_valid = 1'b0; ifa.bit_in = 1'b0; ifa.out_ready = 1'b0;
      ifb.start = 1'b0; ifb.bit_valid = 1'b0; ifb.bit_in = 1'b0; ifb.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_pattern();
      test_extremes();
      test_gaps();
      test_back_to_back();
      test_async_reset();
      test_long();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stochastic_to_binary.md
Name: stochastic_to_binary

Overview:
Serial unipolar stochastic-to-binary converter. It sits directly downstream of the stochastic multiplier's serial (clocked) output and counts the ones in an N-bit bitstream window. It returns the count as a binary value, and the encoded probability is count/N. It uses start/valid input sequencing and a valid/ready output handshake so results can be back-pressured.

Parameters:
N, 16384, bitstream window length in bits; legal values are 2 and above.
CW, $clog2(N+1), width of the ones count; it must be able to hold the value N.
LW, $clog2(N), width of the internal length counter.

Ports:
clk  input  1  single clock; all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new conversion window; sampled on clk.
bit_valid  input  1  bit_in carries a stream bit this cycle.
bit_in  input  1  serial stochastic bit (e.g. the AND output of the upstream multiplier).
busy  output  1  high while a window is being accumulated.
out_valid  output  1  result available on count.
out_ready  input  1  downstream accepts the result.
count  output  CW  number of ones in the completed window, range 0..N.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; busy=0, out_valid=0, count=0.
  - Internal ones counter = 0, length counter = 0.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - busy=0, out_valid=0.
  - bit_valid and out_ready are ignored.
  - start=1: clear ones/length counters, go to ACCUM next cycle.
- ACCUM:
  - busy=1.
  - Each cycle with bit_valid=1: length += 1 and ones += bit_in.
  - Cycles with bit_valid=0 change nothing, whatever bit_in is.
  - start is ignored; no restart mid-window.
  - On the cycle the Nth valid bit is accepted (length == N-1 and bit_valid=1):
    - count <= ones + bit_in.
    - Go to HOLD; out_valid=1 and busy=0 from the next cycle.
  - Latency: out_valid rises exactly 1 cycle after the Nth accepted bit.
- HOLD:
  - out_valid=1; count is stable until the handshake completes.
  - bit_valid is ignored; bits arriving here are dropped.
  - out_valid & out_ready:
    - Result consumed.
    - Next state is IDLE, or ACCUM with counters cleared if start=1 in the same cycle (back-to-back windows, no dead cycle).
  - start without out_ready is ignored.
- Arithmetic:
  - The ones counter is CW bits wide, so count=N (all ones) does not wrap.
  - The length counter is LW bits and never exceeds N-1.
- count keeps its last result after the handshake until the next window completes.
- Reset asserted mid-ACCUM or mid-HOLD aborts the operation. The partial count is discarded and outputs return to their reset values at once.
- Upstream holds bit_in stable while bit_valid=1; no ready is returned on the input side; the block always accepts in ACCUM.

Test Plan:
- N=8, start, then 8 consecutive valid bits 1,0,1,1,0,0,1,0 -> busy=1 for 8 cycles; out_valid=1 one cycle after the 8th bit; count=4.
- N=8, all-ones window then all-zeros window -> count=8 (no wrap, CW=4), then count=0.
- N=8, valid bits interleaved with bit_valid=0 cycles driving bit_in=1 -> count equals the ones among valid bits only; out_valid timing follows the 8th valid bit.
- N=8, out_ready held low 5 cycles in HOLD, start pulsed meanwhile -> out_valid and count stable and start ignored. Then out_ready=1 together with start=1 -> ACCUM the next cycle, with a new window counted correctly.
- N=8, rst asserted asynchronously after 3 valid bits -> busy=0, out_valid=0, count=0 immediately. A following window of 8 ones gives count=8.
- Default N=16384, bit_in = AND of two LFSR-driven streams with p=0.5 and p=0.25 -> count equals the reference-model ones count exactly (about 2048); out_valid exactly 1 cycle after the 16384th bit.
